regfile_demux_wr: RTL and testbench



---
 rtl/regfile_demux_wr.sv | 81 ++++++++
 tb/tb_regfile_demux_wr.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_demux_wr.sv
// Register file with one demultiplexed write port and two combinational read ports.
// Register 0 has no storage and always reads as zero; optional write-through on read/write collision.
module regfile_demux_wr #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit BYPASS     = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2,
    output logic                  wr_done,
    output logic [15:0]           wr_count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DEPTH-1:0]      w_wsel;
    logic                  w_commit;
    logic [DATA_WIDTH-1:0] r_regs [DEPTH-1:1];
    logic                  r_wr_done;
    logic [15:0]           r_wr_count;

    // NOTE: every output of an always_comb block is given a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_wsel = '0;
        if (we && (waddr != '0)) begin
            w_wsel[waddr] = 1'b1;
        end
    end

    assign w_commit = |w_wsel;

    // NOTE: the storage is reset explicitly so no X can reach the read ports after the first reset; this costs a reset mux per flop.
    for (genvar g = 1; g < DEPTH; g++) begin : g_reg
        always_ff @(posedge clk) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            if (rst) begin
                r_regs[g] <= '0;
            end else if (w_wsel[g]) begin
                r_regs[g] <= wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_done  <= 1'b0;
            r_wr_count <= '0;
        end else begin
            r_wr_done <= w_commit;
            if (w_commit && (r_wr_count != 16'hFFFF)) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
        end
    end

    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] value;
        value = '0;
        if (addr != '0) begin
            if (BYPASS && we && (addr == waddr)) begin
                value = wdata;
            end else begin
                value = r_regs[addr];
            end
        end
        return value;
    endfunction

    assign rdata1   = read_port(raddr1);
    assign rdata2   = read_port(raddr2);
    assign wr_done  = r_wr_done;
    assign wr_count = r_wr_count;

endmodule

// File: tb/tb_regfile_demux_wr.sv
// Directed bench for regfile_demux_wr; one instance without and one with write-through bypass.
module tb_regfile_demux_wr;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1, rdata2, rdata1_bp, rdata2_bp;
    logic        wr_done, wr_done_bp;
    logic [15:0] wr_count, wr_count_bp;

    int tests_run;
    int tests_failed;

    regfile_demux_wr #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b0)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .wr_done(wr_done), .wr_count(wr_count)
    );

    regfile_demux_wr #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b1)) dut_bp (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1_bp), .rdata2(rdata2_bp),
        .wr_done(wr_done_bp), .wr_count(wr_count_bp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge so inputs change and outputs settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(i);
            #1;
            tests_run++;
            if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset_read addr=%0d: got %h/%h expected 0/0", i, rdata1, rdata2);
            end
            tests_run++;
            if (rdata1_bp !== 32'h0 || rdata2_bp !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset_read_bp addr=%0d: got %h/%h expected 0/0", i, rdata1_bp, rdata2_bp);
            end
        end
        tests_run++;
        if (wr_count !== 16'd0 || wr_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_status: got count=%0d done=%b expected count=0 done=0", wr_count, wr_done);
        end
    endtask

    task automatic test_write_read();
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        tick();
        we = 1'b0; raddr1 = 5'd5;
        #1;
        tests_run++;
        if (rdata1 !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL write_read_r5: got %h expected deadbeef", rdata1);
        end
        tests_run++;
        if (wr_done !== 1'b1 || wr_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL write_status: got done=%b count=%0d expected done=1 count=1", wr_done, wr_count);
        end
        tick();
        tests_run++;
        if (wr_done !== 1'b0 || wr_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL write_done_pulse: got done=%b count=%0d expected done=0 count=1", wr_done, wr_count);
        end
    endtask

    task automatic test_zero_write();
        we = 1'b1; waddr = 5'd0; wdata = 32'h12345678; raddr2 = 5'd0;
        #1;
        tests_run++;
        if (rdata2 !== 32'h0 || rdata2_bp !== 32'h0) begin
            tests_failed++;
            $display("FAIL zero_write_same_cycle: got %h/%h expected 0/0", rdata2, rdata2_bp);
        end
        tick();
        we = 1'b0;
        #1;
        tests_run++;
        if (rdata2 !== 32'h0 || rdata2_bp !== 32'h0) begin
            tests_failed++;
            $display("FAIL zero_write_after: got %h/%h expected 0/0", rdata2, rdata2_bp);
        end
        tests_run++;
        if (wr_done !== 1'b0 || wr_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL zero_write_status: got done=%b count=%0d expected done=0 count=1", wr_done, wr_count);
        end
    endtask

    task automatic test_collision();
        we = 1'b1; waddr = 5'd7; wdata = 32'h1;
        tick();
        wdata = 32'h2; raddr1 = 5'd7;
        #1;
        tests_run++;
        if (rdata1 !== 32'h1) begin
            tests_failed++;
            $display("FAIL collision_no_bypass: got %h expected 00000001", rdata1);
        end
        tests_run++;
        if (rdata1_bp !== 32'h2) begin
            tests_failed++;
            $display("FAIL collision_bypass: got %h expected 00000002", rdata1_bp);
        end
        tick();
        we = 1'b0;
        #1;
        tests_run++;
        if (rdata1 !== 32'h2 || rdata1_bp !== 32'h2) begin
            tests_failed++;
            $display("FAIL collision_after_edge: got %h/%h expected 2/2", rdata1, rdata1_bp);
        end
        tests_run++;
        if (wr_count !== 16'd3 || wr_count_bp !== 16'd3) begin
            tests_failed++;
            $display("FAIL collision_count: got %0d/%0d expected 3/3", wr_count, wr_count_bp);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp1, exp2;
        int          done_cycles;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        done_cycles = 0;
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; waddr = 5'(i); wdata = 32'(i) * 32'h01010101;
            tick();
            if (wr_done === 1'b1) done_cycles++;
        end
        we = 1'b0;
        tests_run++;
        if (done_cycles != 31) begin
            tests_failed++;
            $display("FAIL b2b_done_high: got %0d cycles expected 31", done_cycles);
        end
        tests_run++;
        if (wr_count !== 16'd31) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d expected 31", wr_count);
        end
        tick();
        tests_run++;
        if (wr_done !== 1'b0 || wr_count !== 16'd31) begin
            tests_failed++;
            $display("FAIL b2b_idle: got done=%b count=%0d expected done=0 count=31", wr_done, wr_count);
        end
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(31 - i);
            exp1 = 32'(i) * 32'h01010101;
            exp2 = 32'(31 - i) * 32'h01010101;
            #1;
            tests_run++;
            if (rdata1 !== exp1 || rdata2 !== exp2) begin
                tests_failed++;
                $display("FAIL b2b_read i=%0d: got %h/%h expected %h/%h", i, rdata1, rdata2, exp1, exp2);
            end
            tests_run++;
            if (rdata1_bp !== exp1 || rdata2_bp !== exp2) begin
                tests_failed++;
                $display("FAIL b2b_read_bp i=%0d: got %h/%h expected %h/%h", i, rdata1_bp, rdata2_bp, exp1, exp2);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        rst = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'h0000FFFF;
        tick();
        rst = 1'b0; we = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(i);
            #1;
            tests_run++;
            if (rdata1 !== 32'h0 || rdata2_bp !== 32'h0) begin
                tests_failed++;
                $display("FAIL rst_mid_clear addr=%0d: got %h/%h expected 0/0", i, rdata1, rdata2_bp);
            end
        end
        tests_run++;
        if (wr_count !== 16'd0 || wr_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_status: got count=%0d done=%b expected count=0 done=0", wr_count, wr_done);
        end
        we = 1'b1; waddr = 5'd3; wdata = 32'h000000A5;
        tick();
        we = 1'b0; raddr1 = 5'd3;
        #1;
        tests_run++;
        if (rdata1 !== 32'h000000A5) begin
            tests_failed++;
            $display("FAIL rst_mid_resume: got %h expected 000000a5", rdata1);
        end
        tests_run++;
        if (wr_count !== 16'd1 || wr_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_resume_status: got count=%0d done=%b expected count=1 done=1", wr_count, wr_done);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_write_read();
        test_zero_write();
        test_collision();
        test_back_to_back();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
